// File: rtl/sha256_axi_pkg.sv
// Shared AXI4 encodings, FSM state type and the 4KB-boundary helper for the
// SHA256 burst master.
package sha256_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_4B     = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5
  } state_t;

  // A burst of (len+1) 4-byte beats must end at or before the next 4KB page.
  function automatic logic crosses_4k(input logic [11:0] addr_lo, input logic [7:0] len);
    logic [13:0] end_addr;
    end_addr = {2'b00, addr_lo[11:2], 2'b00} + {3'b000, ({1'b0, len} + 9'd1), 2'b00};
    return end_addr > 14'd4096;
  endfunction

endpackage

// File: rtl/sha256_axi_burst_master_if.sv
// AXI4-full bus bundle between the burst master and a memory-mapped slave.
interface sha256_axi_burst_master_if #(
  parameter int ID_W   = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/sha256_axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master: one read or write command of
// 1..256 beats, with write data from and read data to valid/ready streams.
module sha256_axi_burst_master
  import sha256_axi_pkg::*;
#(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                          m00_axi_aclk,
  input  logic                          m00_axi_aresetn,

  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]                    cmd_len,

  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] wr_data,

  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rd_data,
  output logic                          rd_last,

  output logic                          done,
  output logic                          err,

  sha256_axi_burst_master_if.master     m00_axi
);

  state_t                        state, state_nxt;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                    len_q;
  logic [7:0]                    cnt;
  logic                          rd_err_q;
  logic                          done_q, err_q;

  logic cmd_hs, bad_4k, last_beat, w_hs, r_hs, b_hs;
  logic unused_bits;

  assign cmd_hs    = cmd_valid && (state == ST_IDLE);
  assign bad_4k    = crosses_4k(cmd_addr[11:0], cmd_len);
  assign last_beat = (cnt == len_q);
  assign w_hs      = m00_axi.wvalid && m00_axi.wready;
  assign r_hs      = m00_axi.rvalid && m00_axi.rready;
  assign b_hs      = m00_axi.bvalid && m00_axi.bready;

  // Byte lanes below the word and the returned IDs carry no information here.
  assign unused_bits = ^{cmd_addr[1:0], m00_axi.bid, m00_axi.rid};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) state <= ST_IDLE;
    else                  state <= state_nxt;
  end

  // NOTE: defaulting state_nxt first keeps every path assigned, so no latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_hs && !bad_4k) state_nxt = cmd_write ? ST_AW : ST_AR;
      ST_AR:   if (m00_axi.arready) state_nxt = ST_R;
      ST_R:    if (r_hs && m00_axi.rlast) state_nxt = ST_IDLE;
      ST_AW:   if (m00_axi.awready) state_nxt = ST_W;
      ST_W:    if (w_hs && last_beat) state_nxt = ST_B;
      ST_B:    if (m00_axi.bvalid) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are pure functions of state plus zero-latency passthroughs.
  always_comb begin
    cmd_ready       = (state == ST_IDLE);
    m00_axi.awvalid = (state == ST_AW);
    m00_axi.arvalid = (state == ST_AR);
    m00_axi.wvalid  = (state == ST_W) && wr_valid;
    wr_ready        = (state == ST_W) && m00_axi.wready;
    m00_axi.wlast   = (state == ST_W) && last_beat;
    m00_axi.bready  = (state == ST_B);
    rd_valid        = (state == ST_R) && m00_axi.rvalid;
    m00_axi.rready  = (state == ST_R) && rd_ready;
    rd_last         = (state == ST_R) && m00_axi.rlast;
  end

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      addr_q   <= '0;
      len_q    <= '0;
      cnt      <= '0;
      rd_err_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (cmd_hs) begin
        addr_q   <= {cmd_addr[C_M_AXI_ADDR_WIDTH-1:2], 2'b00};
        len_q    <= cmd_len;
        cnt      <= '0;
        rd_err_q <= 1'b0;
        if (bad_4k) begin
          done_q <= 1'b1;
          err_q  <= 1'b1;
        end
      end
      if (w_hs && !last_beat) cnt <= cnt + 8'd1;
      if (b_hs) begin
        done_q <= 1'b1;
        err_q  <= (m00_axi.bresp != RESP_OKAY);
      end
      if (r_hs) begin
        if (m00_axi.rlast) begin
          done_q <= 1'b1;
          err_q  <= rd_err_q || (m00_axi.rresp != RESP_OKAY) || !last_beat;
        end else begin
          // A non-final beat at or past len means the slave overran the burst.
          if ((m00_axi.rresp != RESP_OKAY) || last_beat) rd_err_q <= 1'b1;
          if (cnt != 8'hFF) cnt <= cnt + 8'd1;
        end
      end
    end
  end

  assign done    = done_q;
  assign err     = err_q;
  assign rd_data = m00_axi.rdata;

  assign m00_axi.awid    = {C_M_AXI_ID_WIDTH{1'b0}};
  assign m00_axi.awaddr  = addr_q;
  assign m00_axi.awlen   = len_q;
  assign m00_axi.awsize  = SIZE_4B;
  assign m00_axi.awburst = BURST_INCR;
  assign m00_axi.awlock  = 1'b0;
  assign m00_axi.awcache = 4'b0011;
  assign m00_axi.awprot  = 3'b000;
  assign m00_axi.awqos   = 4'b0000;
  assign m00_axi.wdata   = wr_data;
  assign m00_axi.wstrb   = {(C_M_AXI_DATA_WIDTH/8){1'b1}};

  assign m00_axi.arid    = {C_M_AXI_ID_WIDTH{1'b0}};
  assign m00_axi.araddr  = addr_q;
  assign m00_axi.arlen   = len_q;
  assign m00_axi.arsize  = SIZE_4B;
  assign m00_axi.arburst = BURST_INCR;
  assign m00_axi.arlock  = 1'b0;
  assign m00_axi.arcache = 4'b0011;
  assign m00_axi.arprot  = 3'b000;
  assign m00_axi.arqos   = 4'b0000;

endmodule
